score_table: RTL and testbench

Parametrised top-N high-score table for the game score path. On each slime death it captures the BCD score as the last score, then inserts it in rank order into a DEPTH-entry leaderboard using a multi-cycle scan/insert state machine. It sits beside the score counter and feeds the display/menu logic through a registered read port.

---
 rtl/score_table_pkg.sv | 29 ++
 rtl/score_table_if.sv | 45 ++++
 rtl/score_shift_row.sv | 38 +++
 rtl/score_table.sv | 144 ++++++++++++++
 tb/tb_score_table.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/score_table_pkg.sv
// Shared types and constants for the score_table leaderboard.
// Optional table clear input is enabled by SCORE_TABLE_CLEAR_EN.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        INSERT
    } state_e;

    typedef enum logic [1:0] {
        ROW_HOLD,
        ROW_CAND,
        ROW_UPPER,
        ROW_SEED
    } row_sel_e;

    localparam logic [31:0] SEED_TOP_DEF = 32'h10;

    function automatic int score_w(input int digits);
        return 4 * digits;
    endfunction

    // A rank equal to the table depth means "not placed".
    function automatic int not_placed(input int depth);
        return depth;
    endfunction

endpackage

// File: rtl/score_table_if.sv
// Handshake/read bundle between the score path and score_table.
// Carries clr only when SCORE_TABLE_CLEAR_EN is defined.
interface score_table_if
    import score_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int DEPTH  = 4
);
    localparam int SW = score_w(DIGITS);
    localparam int IW = $clog2(DEPTH);
    localparam int RW = $clog2(DEPTH + 1);

    logic          slime_die;
    logic [SW-1:0] score;
    logic [IW-1:0] rd_idx;
    logic [SW-1:0] rd_score;
    logic [SW-1:0] top_score;
    logic [SW-1:0] last_score;
    logic          busy;
    logic          done;
    logic [RW-1:0] rank;
    logic          dropped;
`ifdef SCORE_TABLE_CLEAR_EN
    logic          clr;
`endif

    modport master (
`ifdef SCORE_TABLE_CLEAR_EN
        output clr,
`endif
        output slime_die, score, rd_idx,
        input  rd_score, top_score, last_score,
        input  busy, done, rank, dropped
    );

    modport slave (
`ifdef SCORE_TABLE_CLEAR_EN
        input  clr,
`endif
        input  slime_die, score, rd_idx,
        output rd_score, top_score, last_score,
        output busy, done, rank, dropped
    );

endinterface

// File: rtl/score_shift_row.sv
// One leaderboard entry: hold, take the candidate, take the row above,
// or return to its reset value.
module score_shift_row
    import score_pkg::*;
#(
    parameter int             SW      = 8,
    parameter logic [SW-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  row_sel_e      sel_i,
    input  logic [SW-1:0] cand_i,
    input  logic [SW-1:0] upper_i,
    output logic [SW-1:0] q_o
);

    logic [SW-1:0] q_q;
    logic [SW-1:0] q_d;

    always_comb begin
        q_d = q_q;
        unique case (sel_i)
            ROW_HOLD:  q_d = q_q;
            ROW_CAND:  q_d = cand_i;
            ROW_UPPER: q_d = upper_i;
            ROW_SEED:  q_d = RST_VAL;
            default:   q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= RST_VAL;
        else     q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/score_table.sv
// Top-N BCD high-score table with a scan/insert FSM and registered read.
// Define SCORE_TABLE_CLEAR_EN to add the synchronous clr input.
module score_table
    import score_pkg::*;
#(
    parameter int          DIGITS   = 2,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] SEED_TOP = SEED_TOP_DEF
) (
    input logic         clk,
    input logic         rst,
    score_table_if.slave bus
);

    localparam int SW = score_w(DIGITS);
    localparam int IW = $clog2(DEPTH);
    localparam int RW = $clog2(DEPTH + 1);
    localparam logic [RW-1:0] NP = RW'(not_placed(DEPTH));

    state_e        state_q;
    logic [IW-1:0] idx_q;
    logic [RW-1:0] pos_q;
    logic [SW-1:0] cand_q;
    logic [SW-1:0] last_q;
    logic [RW-1:0] rank_q;
    logic          busy_q;
    logic          done_q;
    logic          dropped_q;
    logic [SW-1:0] rd_q;

    logic [SW-1:0] ent [DEPTH];
    logic [SW-1:0] up  [DEPTH];
    row_sel_e      row_sel [DEPTH];
    logic          clr_go;

`ifdef SCORE_TABLE_CLEAR_EN
    assign clr_go = (state_q == IDLE) && bus.clr;
`else
    assign clr_go = 1'b0;
`endif

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            row_sel[k] = ROW_HOLD;
            if (clr_go) begin
                row_sel[k] = ROW_SEED;
            end else if (state_q == INSERT && pos_q < NP) begin
                if (RW'(k) == pos_q)     row_sel[k] = ROW_CAND;
                else if (RW'(k) > pos_q) row_sel[k] = ROW_UPPER;
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_row
        if (k == 0) begin : g_top
            assign up[k] = '0;
        end else begin : g_low
            assign up[k] = ent[k-1];
        end
        score_shift_row #(
            .SW      (SW),
            .RST_VAL ((k == 0) ? SW'(SEED_TOP) : '0)
        ) u_row (
            .clk     (clk),
            .rst     (rst),
            .sel_i   (row_sel[k]),
            .cand_i  (cand_q),
            .upper_i (up[k]),
            .q_o     (ent[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pos_q     <= NP;
            cand_q    <= '0;
            last_q    <= '0;
            rank_q    <= NP;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (clr_go) begin
                        last_q    <= '0;
                        rank_q    <= NP;
                        dropped_q <= bus.slime_die;
                    end else if (bus.slime_die) begin
                        last_q  <= bus.score;
                        cand_q  <= bus.score;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    dropped_q <= bus.slime_die;
                    // Strict compare: equal scores keep their older slot.
                    if (cand_q > ent[idx_q]) begin
                        pos_q   <= RW'(idx_q);
                        state_q <= INSERT;
                    end else if (idx_q == IW'(DEPTH - 1)) begin
                        pos_q   <= NP;
                        state_q <= INSERT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                INSERT: begin
                    dropped_q <= bus.slime_die;
                    rank_q    <= pos_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else if (int'(bus.rd_idx) < DEPTH) begin
            rd_q <= ent[bus.rd_idx];
        end else begin
            rd_q <= '0;
        end
    end

    assign bus.rd_score   = rd_q;
    assign bus.top_score  = ent[0];
    assign bus.last_score = last_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.rank       = rank_q;
    assign bus.dropped    = dropped_q;

endmodule

// File: tb/tb_score_table.sv
// Directed bench for score_table with a leaderboard model and a scoreboard
// of pending insertions.
module tb_score_table;
    import score_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [DEPTH-1:0][7:0] tbl;
        int                    rank;
        int                    lat;
        logic [7:0]            last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    score_table_if #(.DIGITS(2), .DEPTH(DEPTH)) bus();

    score_table #(
        .DIGITS   (2),
        .DEPTH    (DEPTH),
        .SEED_TOP (32'h10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t                  exp_q[$];
    logic [DEPTH-1:0][7:0] model;
    int                    nerr = 0;
    int                    nchk = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model    = '0;
        model[0] = 8'h10;
    endtask

    task automatic read_tbl(input logic [DEPTH-1:0][7:0] t);
        for (int k = 0; k < DEPTH; k++) begin
            bus.rd_idx = 2'(k);
            @(negedge clk);
            chk($sformatf("rd_score[%0d]", k), 32'(bus.rd_score), 32'(t[k]));
        end
    endtask

    // Model: first slot holding a strictly smaller score takes the new one.
    task automatic push_exp(input logic [7:0] s);
        exp_t e;
        int   r;
        r = DEPTH;
        for (int k = DEPTH - 1; k >= 0; k--)
            if (s > model[k]) r = k;
        e.tbl = model;
        if (r < DEPTH) begin
            for (int k = DEPTH - 1; k > r; k--) e.tbl[k] = model[k-1];
            e.tbl[r] = s;
        end
        e.rank = r;
        e.lat  = ((r == DEPTH) ? DEPTH - 1 : r) + 2;
        e.last = s;
        model  = e.tbl;
        exp_q.push_back(e);
    endtask

    task automatic drive_die(input logic [7:0] s);
        bus.score     = s;
        bus.slime_die = 1'b1;
        push_exp(s);
        @(negedge clk);
        bus.slime_die = 1'b0;
        chk("busy_after_die", 32'(bus.busy), 32'd1);
        chk("last_after_die", 32'(bus.last_score), 32'(s));
    endtask

    task automatic wait_done(input int cyc0);
        exp_t e;
        int   cyc;
        cyc = cyc0;
        while (!bus.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", 32'(bus.done), 32'd1);
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("done_latency", 32'(cyc - 1), 32'(e.lat));
            chk("rank", 32'(bus.rank), 32'(e.rank));
            chk("busy_in_done", 32'(bus.busy), 32'd0);
            chk("top_score", 32'(bus.top_score), 32'(e.tbl[0]));
            chk("last_score", 32'(bus.last_score), 32'(e.last));
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int seen_done;
        rst           = 1'b1;
        bus.slime_die = 1'b0;
        bus.score     = '0;
        bus.rd_idx    = '0;
`ifdef SCORE_TABLE_CLEAR_EN
        bus.clr       = 1'b0;
`endif
        model_reset();
        #12;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dropped", 32'(bus.dropped), 32'd0);
        chk("rst_rank", 32'(bus.rank), 32'd4);
        chk("rst_last", 32'(bus.last_score), 32'h00);
        chk("rst_top", 32'(bus.top_score), 32'h10);
        chk("rst_rd", 32'(bus.rd_score), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        read_tbl(model);

        drive_die(8'h23);
        wait_done(1);
        chk("rank_23_is_0", 32'(bus.rank), 32'd0);
        read_tbl(model);

        drive_die(8'h10);
        wait_done(1);
        chk("rank_tie_is_2", 32'(bus.rank), 32'd2);
        read_tbl(model);

        pulse_rst();
        drive_die(8'h15);
        wait_done(1);
        drive_die(8'h20);
        wait_done(1);
        drive_die(8'h30);
        wait_done(1);
        drive_die(8'h45);
        wait_done(1);
        read_tbl(model);

        drive_die(8'h07);
        wait_done(1);
        chk("rank_07_not_placed", 32'(bus.rank), 32'd4);
        read_tbl(model);

        drive_die(8'h31);
        bus.score     = 8'h99;
        bus.slime_die = 1'b1;
        @(negedge clk);
        bus.slime_die = 1'b0;
        chk("dropped_pulse", 32'(bus.dropped), 32'd1);
        chk("last_kept_31", 32'(bus.last_score), 32'h31);
        wait_done(2);
        chk("dropped_cleared", 32'(bus.dropped), 32'd0);

        // New event in the done cycle is accepted.
        drive_die(8'h99);
        wait_done(1);
        read_tbl(model);

        bus.score     = 8'h50;
        bus.slime_die = 1'b1;
        @(negedge clk);
        bus.slime_die = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_top", 32'(bus.top_score), 32'h10);
        chk("abort_last", 32'(bus.last_score), 32'h00);
        chk("abort_rank", 32'(bus.rank), 32'd4);
        chk("abort_rd", 32'(bus.rd_score), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) seen_done = 1;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        read_tbl(model);

`ifdef SCORE_TABLE_CLEAR_EN
        drive_die(8'h42);
        wait_done(1);
        @(negedge clk);
        bus.clr       = 1'b1;
        bus.score     = 8'h55;
        bus.slime_die = 1'b1;
        @(negedge clk);
        bus.clr       = 1'b0;
        bus.slime_die = 1'b0;
        chk("clr_dropped", 32'(bus.dropped), 32'd1);
        chk("clr_busy", 32'(bus.busy), 32'd0);
        chk("clr_last", 32'(bus.last_score), 32'h00);
        chk("clr_rank", 32'(bus.rank), 32'd4);
        chk("clr_top", 32'(bus.top_score), 32'h10);
        model_reset();
        read_tbl(model);
`endif

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
